tag_wrr_arbiter: RTL and testbench

- Sits directly downstream of the four-port unpack/SG-DMA stage.
- Consumes the four per-ingress packet-tag streams (first block address, length, priority, destination port) through their valid/ready handshakes.
- Merges them, by weighted round-robin across ingress ports, into one registered tag stream for the queue manager.
- Every accepted tag carries its 2-bit source port.

---
 rtl/tag_pkg.sv | 33 +++
 rtl/rr_next_pick.sv | 44 ++++
 rtl/tag_wrr_arbiter.sv | 135 +++++++++++++
 tb/tb_tag_wrr_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/tag_pkg.sv
// -----------------------------------------------------------------------------
// tag_pkg
// Shared definitions for the packet-tag path: the unpack stage, the tag
// arbiter, the queue manager and the egress scheduler all use these widths
// and the packed tag layout.
//   ADDR_W / LEN_W / PRI_W / PORT_W : tag field widths
//   NPORT / SRC_W                  : number of ingress ports and index width
//   tag_t                          : {fir_addr, len, pri, dst_port}
//   ring_add                       : pointer arithmetic modulo NPORT
// -----------------------------------------------------------------------------
package tag_pkg;

  localparam int ADDR_W = 12;
  localparam int LEN_W  = 4;
  localparam int PRI_W  = 3;
  localparam int PORT_W = 4;
  localparam int NPORT  = 4;
  localparam int SRC_W  = 2;

  typedef struct packed {
    logic [ADDR_W-1:0] fir_addr;
    logic [LEN_W-1:0]  len;
    logic [PRI_W-1:0]  pri;
    logic [PORT_W-1:0] dst_port;
  } tag_t;

  // NPORT is a power of two, so the natural SRC_W-bit wrap is the modulo.
  function automatic logic [SRC_W-1:0] ring_add(input logic [SRC_W-1:0] p,
                                                input logic [SRC_W-1:0] k);
    return p + k;
  endfunction

endpackage

// File: rtl/rr_next_pick.sv
// -----------------------------------------------------------------------------
// rr_next_pick
// Combinational round-robin search. Starting just after ptr, scans
// ptr+1, ptr+2, ptr+3 and finally ptr itself, returning the first index
// with its request bit set. With no request, nxt falls back to ptr.
// Ports:
//   req   in  NPORT   request vector, bit i = requester i
//   ptr   in  SRC_W   current owner
//   nxt   out SRC_W   next owner
//   found out 1       any request present
// -----------------------------------------------------------------------------
module rr_next_pick
  import tag_pkg::*;
(
  input  logic [NPORT-1:0] req,
  input  logic [SRC_W-1:0] ptr,
  output logic [SRC_W-1:0] nxt,
  output logic             found
);

  logic [SRC_W-1:0] cand1;
  logic [SRC_W-1:0] cand2;
  logic [SRC_W-1:0] cand3;

  assign cand1 = ring_add(ptr, 2'd1);
  assign cand2 = ring_add(ptr, 2'd2);
  assign cand3 = ring_add(ptr, 2'd3);
  assign found = |req;

  // Priority search: the current owner is considered last.
  always_comb begin
    nxt = ptr;
    if (req[cand1]) begin
      nxt = cand1;
    end else if (req[cand2]) begin
      nxt = cand2;
    end else if (req[cand3]) begin
      nxt = cand3;
    end else begin
      nxt = ptr;
    end
  end

endmodule

// File: rtl/tag_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tag_wrr_arbiter
// Merges the four per-ingress tag streams from the unpack stage into one
// registered tag stream for the queue manager, by weighted round-robin.
// Ingress i receives at most WEIGHTi consecutive grants per round.
// Ports:
//   iClk, iRst        clock, synchronous active-high reset
//   iPkgTagVld[4]     per-ingress valid
//   iPkgFirAddr[48]   ingress i at [12i+11:12i]
//   iPkgLen[16]       ingress i at [4i+3:4i]
//   iPkgPri[12]       ingress i at [3i+2:3i]
//   iPkgDstPort[16]   ingress i at [4i+3:4i]
//   oWrrRdy[4]        per-ingress ready, one-hot or zero
//   oTagVld, oTagFirAddr, oTagLen, oTagPri, oTagDstPort, oTagSrcPort
//                     registered output tag with its source ingress
//   iQmRdy            queue manager accepts the output tag
// -----------------------------------------------------------------------------
module tag_wrr_arbiter
  import tag_pkg::*;
#(
  parameter int unsigned WEIGHT0 = 4,
  parameter int unsigned WEIGHT1 = 4,
  parameter int unsigned WEIGHT2 = 4,
  parameter int unsigned WEIGHT3 = 4
) (
  input  logic                    iClk,
  input  logic                    iRst,
  input  logic [NPORT-1:0]        iPkgTagVld,
  input  logic [NPORT*ADDR_W-1:0] iPkgFirAddr,
  input  logic [NPORT*LEN_W-1:0]  iPkgLen,
  input  logic [NPORT*PRI_W-1:0]  iPkgPri,
  input  logic [NPORT*PORT_W-1:0] iPkgDstPort,
  output logic [NPORT-1:0]        oWrrRdy,
  output logic                    oTagVld,
  output logic [ADDR_W-1:0]       oTagFirAddr,
  output logic [LEN_W-1:0]        oTagLen,
  output logic [PRI_W-1:0]        oTagPri,
  output logic [PORT_W-1:0]       oTagDstPort,
  output logic [SRC_W-1:0]        oTagSrcPort,
  input  logic                    iQmRdy
);

  // Credits live in a 4-bit counter, so weights must fit 1..15.
  if (WEIGHT0 < 1 || WEIGHT0 > 15 || WEIGHT1 < 1 || WEIGHT1 > 15 ||
      WEIGHT2 < 1 || WEIGHT2 > 15 || WEIGHT3 < 1 || WEIGHT3 > 15) begin : g_bad_weight
    $error("tag_wrr_arbiter: every WEIGHTn must be in 1..15");
  end

  function automatic logic [3:0] weight_of(input logic [SRC_W-1:0] idx);
    logic [3:0] w;
    case (idx)
      2'd0:    w = 4'(WEIGHT0);
      2'd1:    w = 4'(WEIGHT1);
      2'd2:    w = 4'(WEIGHT2);
      2'd3:    w = 4'(WEIGHT3);
      default: w = 4'(WEIGHT0);
    endcase
    return w;
  endfunction

  logic [SRC_W-1:0] ptr;
  logic [3:0]       credit;
  logic             slot_free;
  logic             xfer;
  logic [SRC_W-1:0] nxt_ptr;
  logic             nxt_found;
  tag_t             in_tag [NPORT];
  tag_t             sel_tag;

  // Slice the flat ingress buses into per-port tag structs.
  for (genvar g = 0; g < NPORT; g++) begin : g_unpack
    assign in_tag[g] = {iPkgFirAddr[g*ADDR_W +: ADDR_W],
                        iPkgLen[g*LEN_W +: LEN_W],
                        iPkgPri[g*PRI_W +: PRI_W],
                        iPkgDstPort[g*PORT_W +: PORT_W]};
  end

  assign sel_tag = in_tag[ptr];

  // Ready depends only on registered state (and reset), never on valid, so
  // the unpack stage sees no combinational loop through this block.
  assign slot_free = !oTagVld || iQmRdy;
  assign oWrrRdy   = (slot_free && !iRst) ? (4'b0001 << ptr) : 4'b0000;
  assign xfer      = iPkgTagVld[ptr] && oWrrRdy[ptr];

  rr_next_pick u_next (
    .req   (iPkgTagVld),
    .ptr   (ptr),
    .nxt   (nxt_ptr),
    .found (nxt_found)
  );

  // Output register: load on transfer, clear once consumed, hold on stall.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      oTagVld     <= 1'b0;
      oTagFirAddr <= '0;
      oTagLen     <= '0;
      oTagPri     <= '0;
      oTagDstPort <= '0;
      oTagSrcPort <= '0;
    end else if (xfer) begin
      oTagVld     <= 1'b1;
      oTagFirAddr <= sel_tag.fir_addr;
      oTagLen     <= sel_tag.len;
      oTagPri     <= sel_tag.pri;
      oTagDstPort <= sel_tag.dst_port;
      oTagSrcPort <= ptr;
    end else if (iQmRdy) begin
      oTagVld     <= 1'b0;
    end
  end

  // Pointer/credit update: spend credit on grants, move on at exhaustion,
  // and hop away from an idle owner whenever the output slot is free.
  always_ff @(posedge iClk) begin
    if (iRst) begin
      ptr    <= 2'd0;
      credit <= weight_of(2'd0);
    end else if (xfer && credit <= 4'd1) begin
      ptr    <= nxt_ptr;
      credit <= weight_of(nxt_ptr);
    end else if (xfer) begin
      credit <= credit - 4'd1;
    end else if (!iPkgTagVld[ptr] && slot_free) begin
      if (nxt_found) begin
        ptr    <= nxt_ptr;
        credit <= weight_of(nxt_ptr);
      end else begin
        credit <= weight_of(ptr);
      end
    end
  end

endmodule

// File: tb/tb_tag_wrr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_tag_wrr_arbiter
// Bench for tag_wrr_arbiter with weights 1,2,3,4. A cycle-level reference
// model (pending-owner/remaining-grant bookkeeping with a modulo search)
// checks every cycle; directed sequences and a table add fixed expectations.
// -----------------------------------------------------------------------------
module tb_tag_wrr_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  vld;
  logic [47:0] fir;
  logic [15:0] len;
  logic [11:0] pri;
  logic [15:0] dst;
  logic        qm;
  logic [3:0]  rdy;
  logic        o_vld;
  logic [11:0] o_fir;
  logic [3:0]  o_len;
  logic [2:0]  o_pri;
  logic [3:0]  o_dst;
  logic [1:0]  o_src;

  always #5 clk = ~clk;

  tag_wrr_arbiter #(.WEIGHT0(1), .WEIGHT1(2), .WEIGHT2(3), .WEIGHT3(4)) dut (
    .iClk(clk), .iRst(rst), .iPkgTagVld(vld), .iPkgFirAddr(fir),
    .iPkgLen(len), .iPkgPri(pri), .iPkgDstPort(dst), .oWrrRdy(rdy),
    .oTagVld(o_vld), .oTagFirAddr(o_fir), .oTagLen(o_len), .oTagPri(o_pri),
    .oTagDstPort(o_dst), .oTagSrcPort(o_src), .iQmRdy(qm)
  );

  int n_tot  = 0;
  int n_pass = 0;

  // reference model state
  int W[4] = '{1, 2, 3, 4};
  int m_owner = 0;
  int m_left  = 1;
  bit m_vld   = 1'b0;
  int m_fir = 0, m_len = 0, m_pri = 0, m_dst = 0, m_src = 0;
  int acc_port;

  typedef struct {
    logic [3:0] vld;
    logic       qm;
    int         exp_vld;
    int         exp_src;
  } vec_t;

  vec_t tbl[30];
  int   pat[10] = '{0, 1, 1, 2, 2, 2, 3, 3, 3, 3};

  task automatic chk(input string nm, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  task automatic set_tag(input int p, input int f, input int l, input int r, input int d);
    fir[p*12 +: 12] = f[11:0];
    len[p*4 +: 4]   = l[3:0];
    pri[p*3 +: 3]   = r[2:0];
    dst[p*4 +: 4]   = d[3:0];
  endtask

  task automatic rand_tag(input int p);
    set_tag(p, int'($urandom_range(0, 4095)), int'($urandom_range(0, 15)),
            int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));
  endtask

  // One clock: check ready, advance the model, check the registered tag.
  task automatic step();
    bit free, grant;
    int nxt, c;
    #1;
    free = !m_vld || qm;
    chk("rdy", int'(rdy), (free && !rst) ? (1 << m_owner) : 0);
    grant = !rst && free && vld[m_owner];
    nxt = m_owner;
    for (int k = 1; k <= 4; k++) begin
      c = (m_owner + k) % 4;
      if (vld[c]) begin
        nxt = c;
        break;
      end
    end
    acc_port = grant ? m_owner : -1;
    if (rst) begin
      m_owner = 0; m_left = W[0]; m_vld = 1'b0;
      m_fir = 0; m_len = 0; m_pri = 0; m_dst = 0; m_src = 0;
    end else begin
      if (grant) begin
        m_vld = 1'b1;
        m_fir = int'(fir[m_owner*12 +: 12]);
        m_len = int'(len[m_owner*4 +: 4]);
        m_pri = int'(pri[m_owner*3 +: 3]);
        m_dst = int'(dst[m_owner*4 +: 4]);
        m_src = m_owner;
      end else if (qm) begin
        m_vld = 1'b0;
      end
      if (grant && m_left == 1) begin
        m_owner = nxt; m_left = W[nxt];
      end else if (grant) begin
        m_left = m_left - 1;
      end else if (!vld[m_owner] && free) begin
        m_owner = nxt; m_left = W[nxt];
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("tag_vld", int'(o_vld), int'(m_vld));
    chk("tag_fir", int'(o_fir), m_fir);
    chk("tag_len", int'(o_len), m_len);
    chk("tag_pri", int'(o_pri), m_pri);
    chk("tag_dst", int'(o_dst), m_dst);
    chk("tag_src", int'(o_src), m_src);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, got no finish, required finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; vld = 4'hF; fir = '0; len = '0; pri = '0; dst = '0; qm = 1'b1;
    for (int p = 0; p < 4; p++) set_tag(p, 'hA00 + p, p, p, p + 8);

    // reset held two cycles with every ingress valid
    step(); chk("rst_rdy", int'(rdy), 0); chk("rst_vld", int'(o_vld), 0);
    step(); chk("rst_rdy", int'(rdy), 0); chk("rst_vld", int'(o_vld), 0);
    rst = 1'b0;
    step(); chk("first_src", int'(o_src), 0); chk("first_fir", int'(o_fir), 'hA00);

    // weighted round-robin table, all ingress continuously valid
    rst = 1'b1; step(); rst = 1'b0;
    for (int i = 0; i < 30; i++) tbl[i] = '{4'hF, 1'b1, 1, pat[i % 10]};
    for (int i = 0; i < 30; i++) begin
      vld = tbl[i].vld; qm = tbl[i].qm;
      step();
      chk("wrr_vld", int'(o_vld), tbl[i].exp_vld);
      chk("wrr_src", int'(o_src), tbl[i].exp_src);
    end

    // lone requester on ingress 2
    rst = 1'b1; vld = 4'h0; step(); rst = 1'b0;
    vld = 4'b0100; set_tag(2, 'h100, 1, 2, 3);
    step(); chk("lone_hop_vld", int'(o_vld), 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("lone_vld", int'(o_vld), 1);
      chk("lone_src", int'(o_src), 2);
      chk("lone_fir", int'(o_fir), 'h100 + k);
      if (k < 9) set_tag(2, 'h101 + k, 1, 2, 3);
      else vld[2] = 1'b0;
    end
    step();

    // backpressure with tag {ABC,7,5,9} from ingress 1 in the output
    rst = 1'b1; step(); rst = 1'b0;
    vld = 4'b0010; set_tag(1, 'hABC, 7, 5, 9);
    step();
    step(); chk("bp_load_fir", int'(o_fir), 'hABC);
    set_tag(1, 'h123, 1, 2, 3); qm = 1'b0;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("bp_fir", int'(o_fir), 'hABC); chk("bp_len", int'(o_len), 7);
      chk("bp_pri", int'(o_pri), 5);     chk("bp_dst", int'(o_dst), 9);
      chk("bp_vld", int'(o_vld), 1);     chk("bp_rdy", int'(rdy), 0);
    end
    qm = 1'b1;
    step(); chk("bp_next_fir", int'(o_fir), 'h123); chk("bp_next_vld", int'(o_vld), 1);
    vld = 4'h0; step();

    // idle skip: ingress 3 goes idle with 3 grants left, ingress 2 waiting
    rst = 1'b1; step(); rst = 1'b0;
    vld = 4'b1000; set_tag(3, 'h300, 4, 3, 2);
    step();
    step(); chk("skip_first_src", int'(o_src), 3);
    vld = 4'b0100; set_tag(2, 'h200, 5, 6, 7);
    step(); chk("skip_bubble_vld", int'(o_vld), 0);
    step(); chk("skip_src", int'(o_src), 2); chk("skip_fir", int'(o_fir), 'h200);
    vld = 4'h0; step();

    // reset while a tag is stalled in the output
    rst = 1'b1; step(); rst = 1'b0;
    vld = 4'b0010; set_tag(1, 'h5A5, 3, 4, 6);
    step();
    step(); chk("mr_load_fir", int'(o_fir), 'h5A5);
    set_tag(1, 'h6B6, 2, 1, 12); qm = 1'b0;
    step(); chk("mr_stall_vld", int'(o_vld), 1);
    rst = 1'b1;
    step(); chk("mr_rst_vld", int'(o_vld), 0);
    rst = 1'b0;
    step(); chk("mr_hop_vld", int'(o_vld), 0);
    qm = 1'b1;
    step();
    chk("mr_fir", int'(o_fir), 'h6B6); chk("mr_len", int'(o_len), 2);
    chk("mr_pri", int'(o_pri), 1);     chk("mr_dst", int'(o_dst), 12);
    chk("mr_src", int'(o_src), 1);
    vld = 4'h0; step();

    // randomized traffic; valid is only dropped after acceptance
    for (int n = 0; n < 600; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      qm  = ($urandom_range(0, 3) != 0);
      for (int p = 0; p < 4; p++) begin
        if (!vld[p] && $urandom_range(0, 1) == 1) begin
          vld[p] = 1'b1;
          rand_tag(p);
        end
      end
      step();
      if (acc_port >= 0) begin
        vld[acc_port] = 1'($urandom_range(0, 1));
        rand_tag(acc_port);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
